// File: rtl/fpnew_classifier_pipe.sv
// Classifies NumOperands floating-point operands in the formats FP32, FP64, FP16, FP8 and FP16ALT.
// Produces a RISC-V fclass mask and an info byte per operand, passed through an elastic output pipeline.
module fpnew_classifier_pipe #(
    parameter int unsigned FLEN        = 64,
    parameter int unsigned NumOperands = 3,
    parameter int unsigned NumPipeRegs = 1,
    parameter int unsigned TagWidth    = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumOperands*FLEN-1:0] operands_i,
    input  logic [2:0]                  fmt_i,
    input  logic                        check_box_i,
    input  logic [TagWidth-1:0]         tag_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic                        flush_i,
    output logic [NumOperands*10-1:0]   class_mask_o,
    output logic [NumOperands*8-1:0]    info_o,
    output logic [TagWidth-1:0]         tag_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic                        busy_o
);

    localparam int unsigned DW = TagWidth + NumOperands * 18;

    function automatic logic [17:0] classify(input logic [FLEN-1:0] op,
                                             input logic [2:0]      fmt,
                                             input logic            check_box);
        logic [63:0] opx;
        logic [63:0] low;
        int unsigned w;
        logic        supported, boxed, sign, exp0, exp1, man0, qbit;
        logic [9:0]  mask;
        logic [7:0]  info;
        // Bits above FLEN read as ones so the box test only sees [FLEN-1:w].
        opx            = '1;
        opx[FLEN-1:0]  = op;
        supported      = 1'b1;
        w              = 32;
        sign           = 1'b0;
        exp0           = 1'b0;
        exp1           = 1'b0;
        man0           = 1'b0;
        qbit           = 1'b0;
        case (fmt)
            3'd0: begin
                w = 32; sign = opx[31]; exp0 = ~|opx[30:23]; exp1 = &opx[30:23];
                man0 = ~|opx[22:0]; qbit = opx[22];
            end
            3'd1: begin
                w = 64; sign = opx[63]; exp0 = ~|opx[62:52]; exp1 = &opx[62:52];
                man0 = ~|opx[51:0]; qbit = opx[51];
            end
            3'd2: begin
                w = 16; sign = opx[15]; exp0 = ~|opx[14:10]; exp1 = &opx[14:10];
                man0 = ~|opx[9:0]; qbit = opx[9];
            end
            3'd3: begin
                w = 8; sign = opx[7]; exp0 = ~|opx[6:2]; exp1 = &opx[6:2];
                man0 = ~|opx[1:0]; qbit = opx[1];
            end
            3'd4: begin
                w = 16; sign = opx[15]; exp0 = ~|opx[14:7]; exp1 = &opx[14:7];
                man0 = ~|opx[6:0]; qbit = opx[6];
            end
            default: supported = 1'b0;
        endcase
        low   = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        boxed = !check_box || (w == FLEN) || (&(opx | low));
        if (!supported || (w > FLEN) || !boxed) begin
            mask = 10'h200; info = 8'h50;
        end else if (exp1) begin
            if (man0) begin
                mask = sign ? 10'h001 : 10'h080; info = 8'h88;
            end else if (qbit) begin
                mask = 10'h200; info = 8'hD0;
            end else begin
                mask = 10'h100; info = 8'hB0;
            end
        end else if (exp0) begin
            if (man0) begin
                mask = sign ? 10'h008 : 10'h010; info = 8'h84;
            end else begin
                mask = sign ? 10'h004 : 10'h020; info = 8'h82;
            end
        end else begin
            mask = sign ? 10'h002 : 10'h040; info = 8'h81;
        end
        return {mask, info};
    endfunction

    logic [NumOperands*10-1:0] mask_c;
    logic [NumOperands*8-1:0]  info_c;
    logic [DW-1:0]             stage_in;

    always_comb begin
        mask_c = '0;
        info_c = '0;
        for (int i = 0; i < NumOperands; i++) begin
            {mask_c[i*10 +: 10], info_c[i*8 +: 8]} =
                classify(operands_i[i*FLEN +: FLEN], fmt_i, check_box_i);
        end
    end

    assign stage_in = {tag_i, mask_c, info_c};

    if (NumPipeRegs == 0) begin : g_bypass
        assign out_valid_o                       = in_valid_i;
        assign in_ready_o                        = out_ready_i;
        assign {tag_o, class_mask_o, info_o}     = stage_in;
        assign busy_o                            = in_valid_i;
    end else begin : g_pipe
        logic [NumPipeRegs:1]          vld_q, vld_d, rdy;
        logic [NumPipeRegs:1][DW-1:0]  dat_q, dat_d;
        logic [NumPipeRegs:0]          vld_in;
        logic [NumPipeRegs:0][DW-1:0]  dat_in;

        assign vld_in = {vld_q, in_valid_i};
        assign dat_in = {dat_q, stage_in};

        // A stage can accept when it or any stage downstream of it is empty.
        always_comb begin
            rdy = '0;
            for (int k = 1; k <= NumPipeRegs; k++) begin
                rdy[k] = out_ready_i;
                for (int j = k; j <= NumPipeRegs; j++) begin
                    if (!vld_q[j]) rdy[k] = 1'b1;
                end
            end
        end

        always_comb begin
            vld_d = vld_q;
            dat_d = dat_q;
            for (int k = 1; k <= NumPipeRegs; k++) begin
                if (flush_i) begin
                    vld_d[k] = 1'b0;
                end else if (rdy[k]) begin
                    vld_d[k] = vld_in[k-1];
                    if (vld_in[k-1]) dat_d[k] = dat_in[k-1];
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                vld_q <= '0;
                dat_q <= '0;
            end else begin
                vld_q <= vld_d;
                dat_q <= dat_d;
            end
        end

        assign in_ready_o                    = rdy[1];
        assign out_valid_o                   = vld_in[NumPipeRegs];
        assign {tag_o, class_mask_o, info_o} = dat_in[NumPipeRegs];
        assign busy_o                        = in_valid_i | (|vld_q);
    end

endmodule

// File: tb/tb_fpnew_classifier_pipe.sv
// Randomized and directed bench for fpnew_classifier_pipe with a queue-based reference model.
module tb_fpnew_classifier_pipe;

    localparam int FLEN = 64;
    localparam int NOP  = 3;
    localparam int NPR  = 2;
    localparam int TW   = 8;

    logic                 clk = 1'b0;
    logic                 rst_ni = 1'b0;
    logic [NOP*FLEN-1:0]  operands = '0;
    logic [2:0]           fmt = '0;
    logic                 cb = 1'b0;
    logic [TW-1:0]        tag_i = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 flush = 1'b0;
    logic [NOP*10-1:0]    class_mask;
    logic [NOP*8-1:0]     info;
    logic [TW-1:0]        tag_o;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic                 busy;

    fpnew_classifier_pipe #(
        .FLEN(FLEN), .NumOperands(NOP), .NumPipeRegs(NPR), .TagWidth(TW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .operands_i(operands), .fmt_i(fmt),
        .check_box_i(cb), .tag_i(tag_i), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .flush_i(flush), .class_mask_o(class_mask), .info_o(info), .tag_o(tag_o),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0]     tag;
        logic [NOP*10-1:0] mask;
        logic [NOP*8-1:0]  info;
        int                acc;
    } txn_t;

    txn_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_out = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void geom(input logic [2:0] f, output int w, output int eb,
                                 output int mb, output bit ok);
        ok = 1'b1;
        case (f)
            3'd0:    begin w = 32; eb = 8;  mb = 23; end
            3'd1:    begin w = 64; eb = 11; mb = 52; end
            3'd2:    begin w = 16; eb = 5;  mb = 10; end
            3'd3:    begin w = 8;  eb = 5;  mb = 2;  end
            3'd4:    begin w = 16; eb = 8;  mb = 7;  end
            default: begin w = 0;  eb = 0;  mb = 0;  ok = 1'b0; end
        endcase
    endfunction

    // Reference classification from sign/exponent/mantissa values.
    function automatic logic [17:0] model_class(input logic [63:0] op, input logic [2:0] f,
                                                input logic c);
        int w, eb, mb;
        bit ok;
        longint unsigned v, s, e, m, emax;
        geom(f, w, eb, mb, ok);
        if (!ok || w > FLEN) return {10'h200, 8'h50};
        if (c && w < FLEN && (op >> w) != ((64'd1 << (FLEN - w)) - 64'd1))
            return {10'h200, 8'h50};
        v    = (w == 64) ? op : (op & ((64'd1 << w) - 64'd1));
        s    = (v >> (w - 1)) & 1;
        emax = (64'd1 << eb) - 1;
        e    = (v >> mb) & emax;
        m    = v & ((64'd1 << mb) - 1);
        if (e == emax) begin
            if (m == 0) return {(s != 0) ? 10'h001 : 10'h080, 8'h88};
            if (((m >> (mb - 1)) & 1) != 0) return {10'h200, 8'hD0};
            return {10'h100, 8'hB0};
        end
        if (e == 0) begin
            if (m == 0) return {(s != 0) ? 10'h008 : 10'h010, 8'h84};
            return {(s != 0) ? 10'h004 : 10'h020, 8'h82};
        end
        return {(s != 0) ? 10'h002 : 10'h040, 8'h81};
    endfunction

    function automatic logic [63:0] gen_op(input logic [2:0] f);
        int w, eb, mb;
        bit ok;
        longint unsigned r, s, e, m, emax, mmask, v;
        r = {$urandom, $urandom};
        geom(f, w, eb, mb, ok);
        if (!ok) return r;
        emax  = (64'd1 << eb) - 1;
        mmask = (64'd1 << mb) - 1;
        s     = $urandom_range(0, 1);
        case ($urandom_range(0, 6))
            0: begin e = 0; m = 0; end
            1: begin e = 0; m = r & mmask; if (m == 0) m = 1; end
            2: begin e = 1 + (r % (emax - 1)); m = (r >> 7) & mmask; end
            3: begin e = emax; m = 0; end
            4: begin e = emax; m = (r & mmask) | (64'd1 << (mb - 1)); end
            5: begin e = emax; m = r & (mmask >> 1); if (m == 0) m = 1; end
            default: begin e = (r >> mb) & emax; m = r & mmask; s = r >> 63; end
        endcase
        v = (s << (w - 1)) | (e << mb) | m;
        if (w < 64) begin
            if ($urandom_range(0, 4) != 0) v = v | ~((64'd1 << w) - 1);
            else v = v | ({$urandom, $urandom} & ~((64'd1 << w) - 1));
        end
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: handshakes, occupancy-derived ready/valid, and output data.
    always @(negedge clk) begin : monitor
        txn_t n, e;
        logic [17:0] r;
        if (rst_ni) begin
            check("in_ready", 64'(in_ready), 64'(out_ready || q.size() < NPR));
            check("out_valid", 64'(out_valid),
                  64'(q.size() > 0 && (cyc - q[0].acc) >= NPR));
            check("busy", 64'(busy), 64'(in_valid || q.size() > 0));
            if (out_valid) begin
                for (int k = 0; k < NOP; k++)
                    check("onehot", 64'($countones(class_mask[k*10 +: 10])), 64'd1);
            end
            if (out_valid && out_ready && q.size() > 0) begin
                e = q.pop_front();
                n_out++;
                check("out_tag", 64'(tag_o), 64'(e.tag));
                check("out_mask", 64'(class_mask), 64'(e.mask));
                check("out_info", 64'(info), 64'(e.info));
            end
            if (flush) begin
                q.delete();
            end else if (in_valid && in_ready) begin
                n.tag = tag_i;
                n.mask = '0;
                n.info = '0;
                for (int k = 0; k < NOP; k++) begin
                    r = model_class(operands[k*FLEN +: FLEN], fmt, cb);
                    n.mask[k*10 +: 10] = r[17:8];
                    n.info[k*8 +: 8]   = r[7:0];
                end
                n.acc = cyc;
                q.push_back(n);
            end
        end
    end

    task automatic rand_ops();
        fmt = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        cb  = 1'($urandom_range(0, 1));
        operands = {gen_op(fmt), gen_op(fmt), gen_op(fmt)};
    endtask

    task automatic drive(input logic v, input logic [TW-1:0] t, input logic fl);
        @(posedge clk); #1;
        in_valid = v; tag_i = t; flush = fl;
        rand_ops();
    endtask

    task automatic drain();
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (NPR + 3) @(posedge clk);
        #1;
        check("drain", 64'(q.size()), 64'd0);
    endtask

    task automatic direct(input logic [63:0] op, input logic [2:0] f, input logic c,
                          input logic [TW-1:0] t, input logic [9:0] em, input logic [7:0] ei);
        int cnt;
        drain();
        @(posedge clk); #1;
        operands = {op, op, op}; fmt = f; cb = c; tag_i = t; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!out_valid && cnt < 10);
        check("latency", 64'(cnt), 64'(NPR));
        check("dir_tag", 64'(tag_o), 64'(t));
        for (int k = 0; k < NOP; k++) begin
            check("dir_mask", 64'(class_mask[k*10 +: 10]), 64'(em));
            check("dir_info", 64'(info[k*8 +: 8]), 64'(ei));
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int idx, guard, out0;
        #3;
        in_valid = 1'b0;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_mask", 64'(class_mask), 64'd0);
        check("rst_info", 64'(info), 64'd0);
        check("rst_tag", 64'(tag_o), 64'd0);
        in_valid = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'd1);
        in_valid = 1'b0;
        #20 rst_ni = 1'b1;

        direct(64'hFFFFFFFF_3F800000, 3'd0, 1'b1, 8'h11, 10'h040, 8'h81);
        direct(64'h00000000_3F800000, 3'd0, 1'b1, 8'h12, 10'h200, 8'h50);
        direct(64'h00000000_3F800000, 3'd0, 1'b0, 8'h13, 10'h040, 8'h81);
        direct(64'hFFFFFFFF_FFFF7C01, 3'd2, 1'b1, 8'h14, 10'h100, 8'hB0);
        direct(64'hFFFFFFFF_FFFFFC00, 3'd2, 1'b1, 8'h15, 10'h001, 8'h88);
        direct(64'hFFFFFFFF_FFFF8001, 3'd2, 1'b1, 8'h16, 10'h004, 8'h82);
        direct(64'hFFFFFFFF_FFFF0000, 3'd2, 1'b1, 8'h17, 10'h010, 8'h84);
        direct(64'hFFFFFFFF_FFFFFF7E, 3'd3, 1'b1, 8'h18, 10'h200, 8'hD0);
        direct(64'hFFFFFFFF_FFFFFF80, 3'd4, 1'b1, 8'h19, 10'h001, 8'h88);
        direct(64'h7FF00000_00000001, 3'd1, 1'b1, 8'h1A, 10'h100, 8'hB0);
        direct(64'h00000000_3F800000, 3'd5, 1'b0, 8'h1B, 10'h200, 8'h50);

        // Back-pressure: two slots fill, third offer waits.
        drain();
        @(posedge clk); #1;
        out_ready = 1'b0;
        idx = 0;
        out0 = n_out;
        for (int c = 0; c < 4; c++) begin
            in_valid = (idx < 3); tag_i = 8'hA0 + 8'(idx); rand_ops();
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
        end
        check("stall_accepted", 64'(idx), 64'd2);
        check("stall_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        guard = 0;
        while (idx < 3 && guard < 20) begin
            in_valid = 1'b1; tag_i = 8'hA0 + 8'(idx); rand_ops();
            @(negedge clk);
            if (in_ready) idx++;
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        drain();
        check("stall_outputs", 64'(n_out - out0), 64'd3);

        // Flush with two in flight plus an input handshake.
        drive(1'b1, 8'hB0, 1'b0);
        drive(1'b1, 8'hB1, 1'b0);
        drive(1'b1, 8'hB2, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_busy", 64'(busy), 64'd0);
        drain();

        // Asynchronous reset with transactions in flight.
        drive(1'b1, 8'hC0, 1'b0);
        drive(1'b1, 8'hC1, 1'b0);
        @(posedge clk); #3;
        rst_ni = 1'b0;
        in_valid = 1'b0;
        q.delete();
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_mask", 64'(class_mask), 64'd0);
        check("arst_info", 64'(info), 64'd0);
        check("arst_tag", 64'(tag_o), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #3;
        rst_ni = 1'b1;
        direct(64'hFFFFFFFF_BF800000, 3'd0, 1'b1, 8'hD0, 10'h002, 8'h81);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 39) == 0);
            tag_i     = 8'($urandom);
            rand_ops();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
